pio_mem_decode: RTL and testbench

//  PIO slave-side decoder between the PIO bus and up to NUM_MEM PIO-accessible memories.

---
 rtl/pio_mem_decode.sv | 191 +++++++++++++++++++
 tb/tb_pio_mem_decode.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_mem_decode.sv
// pio_mem_decode: PIO slave-side decoder in front of up to NumMem PIO-accessible memories.
// It accepts one PIO request at a time. Address bits [SelLsb +: SelNbits] choose the target
// memory. The decoder waits until that memory's ack is low, then sends a one-cycle
// select/rd/wr pulse. It waits for the rising edge of the memory's ack, and answers the bus
// with a one-cycle reg_ack_o. A bad index or an ack timeout gives an error response instead.
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   reg_*_i          PIO request (address, write data, rd/wr strobes, select)
//   reg_ack_o        one-cycle completion pulse; reg_err_o/reg_rdata_o valid with it
//   reg_busy_o       high whenever a request is in flight (not idle)
//   drop_cnt_o       saturating count of requests dropped while busy
//   mem_addr_o/din_o registered request address/data, shared by all memories
//   mem_rd_o/wr_o    one-cycle strobes coincident with the one-hot mem_ms_o
//   mem_ack_i        per-memory ack level
//   mem_rdata_i      per-memory read data, slice i = [32*i +: 32]
module pio_mem_decode #(
  parameter int unsigned NumMem   = 4,
  parameter int unsigned SelLsb   = 12,
  parameter int unsigned SelNbits = 2,
  parameter int unsigned Timeout  = 64,
  parameter logic [31:0] ErrData  = 32'hDEAD_BEEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          reg_addr_i,
  input  logic [31:0]          reg_din_i,
  input  logic                 reg_rd_i,
  input  logic                 reg_wr_i,
  input  logic                 reg_ms_i,
  output logic                 reg_ack_o,
  output logic                 reg_err_o,
  output logic [31:0]          reg_rdata_o,
  output logic                 reg_busy_o,
  output logic [7:0]           drop_cnt_o,
  output logic [31:0]          mem_addr_o,
  output logic [31:0]          mem_din_o,
  output logic                 mem_rd_o,
  output logic                 mem_wr_o,
  output logic [NumMem-1:0]    mem_ms_o,
  input  logic [NumMem-1:0]    mem_ack_i,
  input  logic [NumMem*32-1:0] mem_rdata_i
);

  localparam int unsigned TmoW = $clog2(Timeout) + 1;

  typedef enum logic [1:0] {StIdle, StDrain, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         din_q, din_d;
  logic                wr_q, wr_d;
  logic [SelNbits-1:0] idx_q, idx_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic [7:0]          drop_q, drop_d;
  logic [NumMem-1:0]   ack_prev_q;

  logic                req;
  logic [SelNbits-1:0] req_idx;
  logic                req_idx_ok;
  logic                ack_cur, ack_old, ack_edge, tmo_hit;
  logic [31:0]         rdata_sel;

  assign req        = reg_ms_i & (reg_rd_i | reg_wr_i);
  assign req_idx    = reg_addr_i[SelLsb +: SelNbits];
  assign req_idx_ok = 32'(req_idx) < NumMem;

  // Mux the selected memory's ack/data. Only indices known to be valid reach here.
  always_comb begin
    ack_cur   = 1'b0;
    ack_old   = 1'b0;
    rdata_sel = '0;
    for (int unsigned i = 0; i < NumMem; i++) begin
      if (idx_q == SelNbits'(i)) begin
        ack_cur   = mem_ack_i[i];
        ack_old   = ack_prev_q[i];
        rdata_sel = mem_rdata_i[32*i +: 32];
      end
    end
  end

  assign ack_edge = ack_cur & ~ack_old;
  assign tmo_hit  = (tmo_q == TmoW'(Timeout - 1));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    din_d    = din_q;
    wr_d     = wr_q;
    idx_d    = idx_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    tmo_d    = tmo_q;
    drop_d   = drop_q;
    mem_ms_o = '0;
    mem_rd_o = 1'b0;
    mem_wr_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          addr_d = reg_addr_i;
          din_d  = reg_din_i;
          wr_d   = reg_wr_i;  // rd and wr together is treated as a write
          idx_d  = req_idx;
          tmo_d  = '0;
          if (!req_idx_ok) begin
            err_d   = 1'b1;
            rdata_d = ErrData;
            state_d = StResp;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        tmo_d = tmo_q + TmoW'(1);
        if (tmo_hit) begin
          err_d   = 1'b1;
          rdata_d = ErrData;
          state_d = StResp;
        end else if (!ack_cur) begin
          // The previous ack has cleared, so the next rising edge belongs to this access.
          mem_ms_o = NumMem'(1) << idx_q;
          mem_rd_o = ~wr_q;
          mem_wr_o = wr_q;
          state_d  = StWait;
        end
      end
      StWait: begin
        tmo_d = tmo_q + TmoW'(1);
        if (ack_edge) begin
          err_d = 1'b0;
          if (!wr_q) begin
            rdata_d = rdata_sel;
          end
          state_d = StResp;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          rdata_d = ErrData;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (req && (state_q != StIdle) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      din_q      <= '0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      tmo_q      <= '0;
      drop_q     <= '0;
      ack_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      wr_q       <= wr_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      tmo_q      <= tmo_d;
      drop_q     <= drop_d;
      ack_prev_q <= mem_ack_i;
    end
  end

  assign reg_ack_o   = (state_q == StResp);
  assign reg_err_o   = reg_ack_o & err_q;
  assign reg_rdata_o = rdata_q;
  assign reg_busy_o  = (state_q != StIdle);
  assign drop_cnt_o  = drop_q;
  assign mem_addr_o  = addr_q;
  assign mem_din_o   = din_q;

endmodule

// File: tb/tb_pio_mem_decode.sv
// Directed bench for pio_mem_decode, built with three memories so that index 3 is invalid.
// Cycle n means the period that follows rising edge n. The request is driven in cycle 0 and
// is captured at edge 1.
module tb_pio_mem_decode;

  localparam int unsigned Num = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       reg_addr, reg_din;
  logic              reg_rd, reg_wr, reg_ms;
  logic              reg_ack, reg_err, reg_busy;
  logic [31:0]       reg_rdata;
  logic [7:0]        drop_cnt;
  logic [31:0]       mem_addr, mem_din;
  logic              mem_rd, mem_wr;
  logic [Num-1:0]    mem_ms, mem_ack;
  logic [Num*32-1:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pio_mem_decode #(
    .NumMem  (Num),
    .SelLsb  (12),
    .SelNbits(2),
    .Timeout (64),
    .ErrData (32'hDEAD_BEEF)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .reg_addr_i (reg_addr),
    .reg_din_i  (reg_din),
    .reg_rd_i   (reg_rd),
    .reg_wr_i   (reg_wr),
    .reg_ms_i   (reg_ms),
    .reg_ack_o  (reg_ack),
    .reg_err_o  (reg_err),
    .reg_rdata_o(reg_rdata),
    .reg_busy_o (reg_busy),
    .drop_cnt_o (drop_cnt),
    .mem_addr_o (mem_addr),
    .mem_din_o  (mem_din),
    .mem_rd_o   (mem_rd),
    .mem_wr_o   (mem_wr),
    .mem_ms_o   (mem_ms),
    .mem_ack_i  (mem_ack),
    .mem_rdata_i(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request for cycle 0 and return in cycle 1 with the bus lines released.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic rd,
                       input logic wr);
    reg_addr = a;
    reg_din  = d;
    reg_rd   = rd;
    reg_wr   = wr;
    reg_ms   = 1'b1;
    tick();
    reg_ms = 1'b0;
    reg_rd = 1'b0;
    reg_wr = 1'b0;
  endtask

  task automatic test_reset();
    logic [121:0] outs;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    outs = {reg_ack, reg_err, reg_busy, mem_rd, mem_wr, mem_ms, drop_cnt, reg_rdata,
            mem_addr, mem_din};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
  endtask

  task automatic test_write();
    issue(32'h0000_1040, 32'hCAFE_0001, 1'b0, 1'b1);
    checks++;
    if ({mem_ms, mem_wr, mem_rd} !== {3'b010, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL write_pulse: got ms=%b wr=%b rd=%b expected ms=010 wr=1 rd=0",
               mem_ms, mem_wr, mem_rd);
    end
    checks++;
    if ({mem_addr, mem_din} !== {32'h0000_1040, 32'hCAFE_0001}) begin
      failures++;
      $display("FAIL write_addr_din: got %h %h expected 00001040 cafe0001", mem_addr, mem_din);
    end
    tick();  // cycle 2
    checks++;
    if ({mem_ms, mem_wr} !== 4'b0) begin
      failures++;
      $display("FAIL write_pulse_width: got ms=%b wr=%b expected 0", mem_ms, mem_wr);
    end
    tick();  // cycle 3: memory acks two cycles after the select
    mem_ack[1] = 1'b1;
    checks++;
    if (reg_ack !== 1'b0) begin
      failures++;
      $display("FAIL write_early_ack: got reg_ack=%b expected 0", reg_ack);
    end
    tick();  // cycle 4
    checks++;
    if ({reg_ack, reg_err, reg_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL write_resp: got ack=%b err=%b rdata=%h expected 1 0 00000000",
               reg_ack, reg_err, reg_rdata);
    end
    tick();  // cycle 5
    mem_ack[1] = 1'b0;
    checks++;
    if ({reg_ack, reg_busy} !== 2'b00) begin
      failures++;
      $display("FAIL write_done: got ack=%b busy=%b expected 0 0", reg_ack, reg_busy);
    end
  endtask

  task automatic test_read();
    issue(32'h0000_2008, 32'h0, 1'b1, 1'b0);
    checks++;
    if ({mem_ms, mem_rd, mem_wr} !== {3'b100, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL read_pulse: got ms=%b rd=%b wr=%b expected ms=100 rd=1 wr=0",
               mem_ms, mem_rd, mem_wr);
    end
    tick();
    tick();
    mem_ack[2] = 1'b1;
    tick();  // cycle 4
    checks++;
    if ({reg_ack, reg_err, reg_rdata} !== {1'b1, 1'b0, 32'h0001_2345}) begin
      failures++;
      $display("FAIL read_resp: got ack=%b err=%b rdata=%h expected 1 0 00012345",
               reg_ack, reg_err, reg_rdata);
    end
    tick();
    mem_ack[2] = 1'b0;
    tick();
    checks++;
    if (reg_rdata !== 32'h0001_2345) begin
      failures++;
      $display("FAIL read_hold: got rdata=%h expected 00012345", reg_rdata);
    end
  endtask

  task automatic test_decode_err();
    issue(32'h0000_3000, 32'h0, 1'b1, 1'b0);
    checks++;
    if ({mem_ms, reg_ack, reg_err, reg_rdata} !== {3'b000, 1'b1, 1'b1, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL decode_err: got ms=%b ack=%b err=%b rdata=%h expected 000 1 1 deadbeef",
               mem_ms, reg_ack, reg_err, reg_rdata);
    end
    tick();
    checks++;
    if ({reg_ack, reg_busy} !== 2'b00) begin
      failures++;
      $display("FAIL decode_err_done: got ack=%b busy=%b expected 0 0", reg_ack, reg_busy);
    end
  endtask

  // Ack 0 is still high from an earlier access for cycles 0..4. The select must wait.
  task automatic test_drain();
    int early = 0;
    mem_ack[0] = 1'b1;
    issue(32'h0000_0010, 32'h0, 1'b1, 1'b0);
    for (int c = 1; c < 5; c++) begin
      if (mem_ms !== 3'b000 || reg_ack !== 1'b0) early++;
      tick();
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL drain_hold: got %0d early select/ack cycles expected 0", early);
    end
    mem_ack[0] = 1'b0;  // cycle 5
    #1;
    checks++;
    if ({mem_ms, mem_rd} !== {3'b001, 1'b1}) begin
      failures++;
      $display("FAIL drain_release: got ms=%b rd=%b expected 001 1", mem_ms, mem_rd);
    end
    tick();
    tick();
    mem_ack[0] = 1'b1;  // cycle 7
    tick();             // cycle 8
    checks++;
    if ({reg_ack, reg_err, reg_rdata} !== {1'b1, 1'b0, 32'h0000_A0A0}) begin
      failures++;
      $display("FAIL drain_resp: got ack=%b err=%b rdata=%h expected 1 0 0000a0a0",
               reg_ack, reg_err, reg_rdata);
    end
    tick();
    mem_ack[0] = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int n = 1;
    issue(32'h0000_1000, 32'h0, 1'b1, 1'b0);
    while (reg_ack !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n != 65) begin
      failures++;
      $display("FAIL timeout_latency: got response in cycle %0d expected 65", n);
    end
    checks++;
    if ({reg_err, reg_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL timeout_resp: got err=%b rdata=%h expected 1 deadbeef", reg_err, reg_rdata);
    end
    tick();
    // Accepted request followed by three requests while busy.
    issue(32'h0000_1000, 32'h0, 1'b1, 1'b0);
    reg_rd = 1'b1;
    reg_ms = 1'b1;
    tick();
    tick();
    tick();
    reg_ms = 1'b0;
    reg_rd = 1'b0;
    checks++;
    if (drop_cnt !== 8'd3) begin
      failures++;
      $display("FAIL drop_burst: got drop_cnt=%0d expected 3", drop_cnt);
    end
    n = 0;
    while (reg_ack !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    // A request in the response cycle is dropped, not accepted.
    reg_wr = 1'b1;
    reg_ms = 1'b1;
    tick();
    reg_wr = 1'b0;
    reg_ms = 1'b0;
    checks++;
    if ({drop_cnt, reg_busy} !== {8'd4, 1'b0}) begin
      failures++;
      $display("FAIL drop_in_resp: got drop_cnt=%0d busy=%b expected 4 0", drop_cnt, reg_busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [121:0] outs;
    int acks = 0;
    issue(32'h0000_2000, 32'h0, 1'b1, 1'b0);
    tick();  // cycle 2, waiting
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_ack[2] = 1'b1;
    #1;
    outs = {reg_ack, reg_err, reg_busy, mem_rd, mem_wr, mem_ms, drop_cnt, reg_rdata,
            mem_addr, mem_din};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got %h expected 0", outs);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (reg_ack !== 1'b0) acks++;
    end
    checks++;
    if (acks != 0) begin
      failures++;
      $display("FAIL reset_mid_late_ack: got %0d acks expected 0", acks);
    end
    mem_ack[2] = 1'b0;
    tick();
    mem_rdata[64 +: 32] = 32'hA5A5_0002;
    issue(32'h0000_2000, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    mem_ack[2] = 1'b1;
    tick();
    checks++;
    if ({reg_ack, reg_err, reg_rdata} !== {1'b1, 1'b0, 32'hA5A5_0002}) begin
      failures++;
      $display("FAIL reset_mid_recover: got ack=%b err=%b rdata=%h expected 1 0 a5a50002",
               reg_ack, reg_err, reg_rdata);
    end
    tick();
    mem_ack[2] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    reg_addr  = '0;
    reg_din   = '0;
    reg_rd    = 1'b0;
    reg_wr    = 1'b0;
    reg_ms    = 1'b0;
    mem_ack   = '0;
    mem_rdata = '0;
    mem_rdata[0  +: 32] = 32'h0000_A0A0;
    mem_rdata[32 +: 32] = 32'h1111_1111;
    mem_rdata[64 +: 32] = 32'h0001_2345;
    test_reset();
    test_write();
    test_read();
    test_decode_err();
    test_drain();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
